dump_tx_sequencer: RTL and testbench

DUMP_TX_SEQUENCER -- requirements
Module: dump_tx_sequencer

---
 rtl/dump_tx_sequencer_pkg.sv | 36 +++
 rtl/dump_tx_sequencer_mux.sv | 46 ++++
 rtl/dump_tx_sequencer.sv | 131 +++++++++++++
 tb/tb_dump_tx_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dump_tx_sequencer_pkg.sv
// Shared debug-dump definitions: FSM state encoding and the word-index layout
// of a full machine-state dump (PC, register file, data memory, cycle count).
package dump_tx_sequencer_pkg;

  // Sequencer states, one word moves through SELECT/LOAD/WAIT_ACK/WAIT_EMPTY
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_WAIT_ACK,
    ST_WAIT_EMPTY,
    ST_DONE
  } dumpState_e;

  // The program counter always leads the dump
  localparam int WORD_IDX_PC = 0;

  // The cycle counter always closes the dump, right after the last memory word
  function automatic int wordIdxCycles(input int numRegs, input int numMemWords);
    return numRegs + numMemWords + 1;
  endfunction

  // PC + registers + memory + cycle count
  function automatic int totalWords(input int numRegs, input int numMemWords);
    return numRegs + numMemWords + 2;
  endfunction

  // Index counter is never narrower than 7 bits so the default 66-word dump
  // (and small variants) can never wrap mid-dump
  function automatic int wordIdxWidth(input int total);
    int w;
    w = $clog2(total);
    return (w < 7) ? 7 : w;
  endfunction

endpackage

// File: rtl/dump_tx_sequencer_mux.sv
// Decodes a dump word index into register/memory read addresses and picks the
// matching data source for the word presented to the serializer.
module dump_word_mux
  import dump_tx_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 32,
  parameter int MEM_ADDR_W    = 5,
  parameter int IDX_W         = 7
) (
  input  logic [IDX_W-1:0]      wordIdx_i,
  input  logic [WORD_WIDTH-1:0] pc_i,
  input  logic [WORD_WIDTH-1:0] cycleCount_i,
  input  logic [WORD_WIDTH-1:0] regData_i,
  input  logic [WORD_WIDTH-1:0] memData_i,
  output logic [4:0]            regAddr_o,
  output logic [MEM_ADDR_W-1:0] memAddr_o,
  output logic [WORD_WIDTH-1:0] word_o
);

  localparam logic [IDX_W-1:0] PC_IDX        = IDX_W'(WORD_IDX_PC);
  localparam logic [IDX_W-1:0] FIRST_REG_IDX = IDX_W'(WORD_IDX_PC + 1);
  localparam logic [IDX_W-1:0] LAST_REG_IDX  = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] FIRST_MEM_IDX = IDX_W'(NUM_REGS + 1);
  localparam logic [IDX_W-1:0] CYCLES_IDX    = IDX_W'(wordIdxCycles(NUM_REGS, NUM_MEM_WORDS));

  // Region decode: the address that is not in use for this index stays at 0
  always_comb begin
    regAddr_o = '0;
    memAddr_o = '0;
    word_o    = '0;
    if (wordIdx_i == PC_IDX) begin
      word_o = pc_i;
    end else if (wordIdx_i <= LAST_REG_IDX) begin
      regAddr_o = 5'(wordIdx_i - FIRST_REG_IDX);
      word_o    = regData_i;
    end else if (wordIdx_i < CYCLES_IDX) begin
      memAddr_o = MEM_ADDR_W'(wordIdx_i - FIRST_MEM_IDX);
      word_o    = memData_i;
    end else begin
      word_o = cycleCount_i;
    end
  end

endmodule

// File: rtl/dump_tx_sequencer.sv
// Walks the full debug dump one word at a time: drives the read address,
// captures the source word, pulses the serializer load and waits for the
// serializer to take the word and drain it before moving on.
module dump_tx_sequencer
  import dump_tx_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 32,
  localparam int MEM_ADDR_W   = (NUM_MEM_WORDS > 1) ? $clog2(NUM_MEM_WORDS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_dump_start,
  input  logic [WORD_WIDTH-1:0] i_pc,
  input  logic [WORD_WIDTH-1:0] i_cycle_count,
  input  logic [WORD_WIDTH-1:0] i_reg_data,
  input  logic [WORD_WIDTH-1:0] i_mem_data,
  input  logic                  i_buffer_empty,
  output logic [4:0]            o_reg_addr,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_buffer_start,
  output logic                  o_busy,
  output logic                  o_dump_done
);

  localparam int TOTAL_WORDS = totalWords(NUM_REGS, NUM_MEM_WORDS);
  localparam int IDX_W       = wordIdxWidth(TOTAL_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);

  dumpState_e            state_q;
  logic [IDX_W-1:0]      wordIdx_q;
  logic [4:0]            regAddr_q;
  logic [MEM_ADDR_W-1:0] memAddr_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  bufferStart_q;
  logic                  busy_q;
  logic                  dumpDone_q;

  logic [4:0]            muxRegAddr;
  logic [MEM_ADDR_W-1:0] muxMemAddr;
  logic [WORD_WIDTH-1:0] muxWord;

  dump_word_mux #(
    .WORD_WIDTH   (WORD_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .NUM_MEM_WORDS(NUM_MEM_WORDS),
    .MEM_ADDR_W   (MEM_ADDR_W),
    .IDX_W        (IDX_W)
  ) wordMux (
    .wordIdx_i   (wordIdx_q),
    .pc_i        (i_pc),
    .cycleCount_i(i_cycle_count),
    .regData_i   (i_reg_data),
    .memData_i   (i_mem_data),
    .regAddr_o   (muxRegAddr),
    .memAddr_o   (muxMemAddr),
    .word_o      (muxWord)
  );

  // Dump FSM with index counter and all outputs registered; LOAD lasting a
  // single cycle is what keeps the serializer load pulse one cycle wide
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      wordIdx_q     <= '0;
      regAddr_q     <= '0;
      memAddr_q     <= '0;
      word_q        <= '0;
      bufferStart_q <= 1'b0;
      busy_q        <= 1'b0;
      dumpDone_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bufferStart_q <= 1'b0;
          dumpDone_q    <= 1'b0;
          if (i_dump_start && i_buffer_empty) begin
            wordIdx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          regAddr_q <= muxRegAddr;
          memAddr_q <= muxMemAddr;
          state_q   <= ST_LOAD;
        end
        ST_LOAD: begin
          word_q        <= muxWord;
          bufferStart_q <= 1'b1;
          state_q       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          bufferStart_q <= 1'b0;
          if (!i_buffer_empty) begin
            state_q <= ST_WAIT_EMPTY;
          end
        end
        ST_WAIT_EMPTY: begin
          if (i_buffer_empty) begin
            if (wordIdx_q == LAST_IDX) begin
              dumpDone_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              wordIdx_q <= wordIdx_q + IDX_W'(1);
              state_q   <= ST_SELECT;
            end
          end
        end
        ST_DONE: begin
          dumpDone_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_reg_addr     = regAddr_q;
  assign o_mem_addr     = memAddr_q;
  assign o_word         = word_q;
  assign o_buffer_start = bufferStart_q;
  assign o_busy         = busy_q;
  assign o_dump_done    = dumpDone_q;

endmodule

// File: tb/tb_dump_tx_sequencer.sv
// Directed bench for dump_tx_sequencer: a behavioural serializer drains each
// word, register/memory models answer reads, and a linear sequence covers
// reset, ignored starts, full dump contents, ack stalls and mid-dump reset.
module tb_dump_tx_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic        i_dump_start;
  logic [31:0] i_pc;
  logic [31:0] i_cycle_count;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        i_buffer_empty;
  logic [4:0]  o_reg_addr;
  logic [4:0]  o_mem_addr;
  logic [31:0] o_word;
  logic        o_buffer_start;
  logic        o_busy;
  logic        o_dump_done;

  int assertCount = 0;
  int failCount   = 0;

  logic        modelEmpty = 1'b1;
  logic        holdBusy   = 1'b0;
  int          holdCycles = 32;
  int          ackDelay   = 1;
  int          ackCnt     = 0;
  int          busyCnt    = 0;
  logic        prevStart  = 1'b0;
  int          pulseCount = 0;
  int          doneCount  = 0;
  logic [31:0] words [0:255];

  dump_tx_sequencer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_dump_start  (i_dump_start),
    .i_pc          (i_pc),
    .i_cycle_count (i_cycle_count),
    .i_reg_data    (i_reg_data),
    .i_mem_data    (i_mem_data),
    .i_buffer_empty(i_buffer_empty),
    .o_reg_addr    (o_reg_addr),
    .o_mem_addr    (o_mem_addr),
    .o_word        (o_word),
    .o_buffer_start(o_buffer_start),
    .o_busy        (o_busy),
    .o_dump_done   (o_dump_done)
  );

  // Free-running clock, rising edge active
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Register file and data memory answer with a tagged copy of the address
  assign i_reg_data     = 32'hA000_0000 + {27'd0, o_reg_addr};
  assign i_mem_data     = 32'hB000_0000 + {27'd0, o_mem_addr};
  assign i_buffer_empty = modelEmpty & ~holdBusy;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic applyStimulus();
    i_dump_start = 1'b1;
    waitCycle();
    i_dump_start = 1'b0;
  endtask

  // Serializer model and word recorder: a load is acknowledged ackDelay cycles
  // later by dropping empty, which returns holdCycles cycles after that
  always @(negedge i_clk) begin
    if (i_reset) begin
      ackCnt     = 0;
      busyCnt    = 0;
      modelEmpty = 1'b1;
      prevStart  = 1'b0;
    end else begin
      if (o_buffer_start) begin
        checkOutput("startNotBackToBack", {31'd0, prevStart}, 32'd0);
        if (pulseCount < 256) words[pulseCount] = o_word;
        pulseCount++;
      end
      if (o_dump_done) doneCount++;
      prevStart = o_buffer_start;
      if (ackCnt > 0) begin
        ackCnt--;
        if (ackCnt == 0) begin
          modelEmpty = 1'b0;
          busyCnt    = holdCycles;
        end
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) modelEmpty = 1'b1;
      end else if (o_buffer_start) begin
        ackCnt = ackDelay;
      end
    end
  end

  // Hard stop in case the sequence itself ever stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int base;
    int doneBase;
    int frozen;
    logic injected;

    i_reset       = 1'b0;
    i_dump_start  = 1'b0;
    i_pc          = 32'h0000_0040;
    i_cycle_count = 32'h0000_1234;
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("resetWord",    o_word,                 32'd0);
    checkOutput("resetRegAddr", {27'd0, o_reg_addr},    32'd0);
    checkOutput("resetMemAddr", {27'd0, o_mem_addr},    32'd0);
    checkOutput("resetStart",   {31'd0, o_buffer_start}, 32'd0);
    checkOutput("resetBusy",    {31'd0, o_busy},        32'd0);
    checkOutput("resetDone",    {31'd0, o_dump_done},   32'd0);
    repeat (2) waitCycle();
    i_reset = 1'b0;
    waitCycle();

    $display("[TB] start while serializer busy must be ignored");
    holdBusy = 1'b1;
    waitCycle();
    applyStimulus();
    repeat (5) waitCycle();
    checkOutput("busyStartIgnoredBusy",   {31'd0, o_busy}, 32'd0);
    checkOutput("busyStartIgnoredPulses", 32'(pulseCount), 32'd0);
    holdBusy = 1'b0;
    waitCycle();

    $display("[TB] full dump with a stray start during word 10");
    base = pulseCount;
    applyStimulus();
    checkOutput("busyAfterStart", {31'd0, o_busy}, 32'd1);
    injected = 1'b0;
    for (int c = 0; c < 6000 && !o_dump_done; c++) begin
      waitCycle();
      if (!injected && pulseCount == base + 11) begin
        i_dump_start = 1'b1;
        injected     = 1'b1;
      end else begin
        i_dump_start = 1'b0;
      end
    end
    i_dump_start = 1'b0;
    checkOutput("dump1Done",      {31'd0, o_dump_done}, 32'd1);
    checkOutput("busyDuringDone", {31'd0, o_busy},      32'd1);
    waitCycle();
    checkOutput("donePulseWidth", {31'd0, o_dump_done}, 32'd0);
    checkOutput("busyAfterDone",  {31'd0, o_busy},      32'd0);
    checkOutput("dump1WordPc", words[base], 32'h0000_0040);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("dump1Reg%0d", i), words[base + 1 + i],  32'hA000_0000 + 32'(i));
      checkOutput($sformatf("dump1Mem%0d", i), words[base + 33 + i], 32'hB000_0000 + 32'(i));
    end
    checkOutput("dump1WordCycles", words[base + 65], 32'h0000_1234);
    repeat (100) waitCycle();
    checkOutput("dump1PulseTotal", 32'(pulseCount - base), 32'd66);
    checkOutput("dump1DoneCount",  32'(doneCount),         32'd1);
    checkOutput("noSecondDump",    {31'd0, o_busy},        32'd0);

    $display("[TB] slow acknowledge, then reset in WAIT_EMPTY of word 20");
    holdCycles = 4;
    ackDelay   = 5;
    base = pulseCount;
    applyStimulus();
    for (int c = 0; c < 100 && pulseCount != base + 1; c++) waitCycle();
    checkOutput("dump2FirstPulse", 32'(pulseCount - base), 32'd1);
    checkOutput("dump2WordPc",     words[base],            32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      checkOutput($sformatf("ackWaitWord%0d", i),   o_word,                  32'h0000_0040);
      checkOutput($sformatf("ackWaitStart%0d", i),  {31'd0, o_buffer_start}, 32'd0);
      checkOutput($sformatf("ackWaitPulses%0d", i), 32'(pulseCount - base),  32'd1);
    end
    for (int c = 0; c < 3000 && !(pulseCount == base + 21 && i_buffer_empty == 1'b0); c++) waitCycle();
    checkOutput("word20Reached", 32'(pulseCount - base), 32'd21);
    waitCycle();
    checkOutput("word20Value",   o_word,              32'hA000_0013);
    checkOutput("word20RegAddr", {27'd0, o_reg_addr}, 32'd19);
    i_reset = 1'b1;
    #1;
    checkOutput("midResetWord",    o_word,                  32'd0);
    checkOutput("midResetRegAddr", {27'd0, o_reg_addr},     32'd0);
    checkOutput("midResetMemAddr", {27'd0, o_mem_addr},     32'd0);
    checkOutput("midResetStart",   {31'd0, o_buffer_start}, 32'd0);
    checkOutput("midResetBusy",    {31'd0, o_busy},         32'd0);
    checkOutput("midResetDone",    {31'd0, o_dump_done},    32'd0);
    frozen = pulseCount;
    repeat (2) waitCycle();
    i_reset = 1'b0;
    repeat (80) waitCycle();
    checkOutput("noPulseAfterReset", 32'(pulseCount - frozen), 32'd0);
    checkOutput("idleAfterReset",    {31'd0, o_busy},          32'd0);

    $display("[TB] fresh dump after reset restarts at PC");
    holdCycles = 3;
    ackDelay   = 1;
    base     = pulseCount;
    doneBase = doneCount;
    applyStimulus();
    for (int c = 0; c < 3000 && !o_dump_done; c++) waitCycle();
    checkOutput("dump3Done", {31'd0, o_dump_done}, 32'd1);
    repeat (3) waitCycle();
    checkOutput("dump3PulseTotal", 32'(pulseCount - base),    32'd66);
    checkOutput("dump3WordPc",     words[base],               32'h0000_0040);
    checkOutput("dump3Reg31",      words[base + 32],          32'hA000_001F);
    checkOutput("dump3Mem0",       words[base + 33],          32'hB000_0000);
    checkOutput("dump3WordCycles", words[base + 65],          32'h0000_1234);
    checkOutput("dump3DoneCount",  32'(doneCount - doneBase), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
